// File: rtl/range_max_scan_if.sv
// range_max_scan_if: request/result bus between the range RAM scanner and its
// surroundings. The slave modport is the scanner's view; master is the driver side.
interface range_max_scan_if #(
  parameter int RAM_ADDR_BITS = 4
);
  logic                     scan;
  logic                     range_done;
  logic [15:0]              count_in;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [15:0]              max_count;
  logic [RAM_ADDR_BITS-1:0] max_index;
  logic [19:0]              max_bcd;

  modport slave (
    input  scan, range_done, count_in,
    output rd_addr, busy, done, err, max_count, max_index, max_bcd
  );

  modport master (
    output scan, range_done, count_in,
    input  rd_addr, busy, done, err, max_count, max_index, max_bcd
  );
endinterface

// File: rtl/range_max_scan.sv
// range_max_scan: sweeps the Collatz range RAM through its read port once range
// reports done, keeping the largest iteration count and the lowest index holding it.
// Optional feature macro: RANGE_MAX_BCD_EN adds an iterative double-dabble stage
// producing max_bcd; without it max_bcd is tied to zero.
module range_max_scan #(
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input logic            clk,
  input logic            reset,
  range_max_scan_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_BCD   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);

  logic [2:0]               state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [15:0]              max_count_q, max_count_d;
  logic [RAM_ADDR_BITS-1:0] max_index_q, max_index_d;
  logic [RAM_ADDR_BITS-1:0] prev_addr;

`ifdef RANGE_MAX_BCD_EN
  logic [35:0] dd_q, dd_d;
  logic [35:0] dd_shift;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [19:0] max_bcd_q, max_bcd_d;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
  always_comb begin
    logic [35:0] adj;
    adj = dd_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (adj[16+4*i +: 4] >= 4'd5) begin
        adj[16+4*i +: 4] = adj[16+4*i +: 4] + 4'd3;
      end
    end
    dd_shift = {adj[34:0], 1'b0};
  end
`endif

  assign prev_addr = rd_addr_q - RAM_ADDR_BITS'(1);

  // Next-state and datapath control for the scan sequence.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    max_count_d = max_count_q;
    max_index_d = max_index_q;
`ifdef RANGE_MAX_BCD_EN
    dd_d        = dd_q;
    bit_cnt_d   = bit_cnt_q;
    max_bcd_d   = max_bcd_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // done/busy settle one cycle after entering DONE, so the flags lag the state.
        if (state_q == S_DONE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        if (bus.scan) begin
          state_d     = bus.range_done ? S_SCAN : S_WAIT;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          rd_addr_d   = '0;
          max_count_d = '0;
          max_index_d = '0;
        end
      end
      S_WAIT: begin
        if (bus.range_done) begin
          state_d   = S_SCAN;
          rd_addr_d = '0;
        end
      end
      S_SCAN: begin
        if (!bus.range_done) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          // count_in lags rd_addr by one cycle; nothing valid while rd_addr is still 0.
          if (rd_addr_q != '0 && bus.count_in > max_count_q) begin
            max_count_d = bus.count_in;
            max_index_d = prev_addr;
          end
          if (rd_addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + RAM_ADDR_BITS'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!bus.range_done) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (bus.count_in > max_count_q) begin
            max_count_d = bus.count_in;
            max_index_d = LAST_ADDR;
          end
`ifdef RANGE_MAX_BCD_EN
          state_d   = S_BCD;
          bit_cnt_d = '0;
`else
          state_d   = S_DONE;
`endif
        end
      end
`ifdef RANGE_MAX_BCD_EN
      S_BCD: begin
        if (bit_cnt_q == 5'd0) begin
          dd_d      = {20'h0, max_count_q};
          bit_cnt_d = 5'd1;
        end else begin
          dd_d = dd_shift;
          if (bit_cnt_q == 5'd16) begin
            state_d   = S_DONE;
            max_bcd_d = dd_shift[35:16];
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
`else
      S_BCD: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      max_count_q <= '0;
      max_index_q <= '0;
`ifdef RANGE_MAX_BCD_EN
      dd_q        <= '0;
      bit_cnt_q   <= '0;
      max_bcd_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      max_count_q <= max_count_d;
      max_index_q <= max_index_d;
`ifdef RANGE_MAX_BCD_EN
      dd_q        <= dd_d;
      bit_cnt_q   <= bit_cnt_d;
      max_bcd_q   <= max_bcd_d;
`endif
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.max_count = max_count_q;
  assign bus.max_index = max_index_q;
`ifdef RANGE_MAX_BCD_EN
  assign bus.max_bcd   = max_bcd_q;
`else
  assign bus.max_bcd   = '0;
`endif

endmodule

// File: tb/tb_range_max_scan.sv
// Testbench for range_max_scan: models the range RAM read port and checks results
// against a reference built from the RAM contents.
module tb_range_max_scan;
  localparam int W = 16;
`ifdef RANGE_MAX_BCD_EN
  localparam int LAT = W + 2 + 17;
`else
  localparam int LAT = W + 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  range_max_scan_if #(.RAM_ADDR_BITS(4)) bus ();

  range_max_scan #(.RAM_WORDS(W), .RAM_ADDR_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [W];
  always @(posedge clk) bus.count_in <= mem[bus.rd_addr];

  int passed = 0;
  int total  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan;
    bus.scan = 1'b1;
    tick();
    bus.scan = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.done !== 1'b1 && cyc < 200);
  endtask

  // Reference: peak value, first index carrying it, and its decimal digits.
  task automatic ref_model(output logic [15:0] m, output logic [3:0] ix, output logic [19:0] b);
    int unsigned n;
    m = 16'd0;
    for (int i = 0; i < W; i++) if (mem[i] > m) m = mem[i];
    ix = 4'd0;
    for (int i = W - 1; i >= 0; i--) if (mem[i] == m) ix = 4'(i);
    b = 20'h0;
`ifdef RANGE_MAX_BCD_EN
    n = m;
    for (int d = 0; d < 5; d++) begin
      b[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
`else
    n = 0;
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.scan = 1'b0; bus.range_done = 1'b1;
    for (int i = 0; i < W; i++) mem[i] = 16'd0;
    tick(); tick();
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      $display("FAIL reset_flags busy/done/err=%b%b%b expected 000", bus.busy, bus.done, bus.err);
    end else passed++;
    total++; if (bus.rd_addr !== 4'd0 || bus.max_count !== 16'd0 || bus.max_index !== 4'd0 || bus.max_bcd !== 20'h0) begin
      $display("FAIL reset_data addr=%0d cnt=%0d idx=%0d bcd=%h expected zeros",
               bus.rd_addr, bus.max_count, bus.max_index, bus.max_bcd);
    end else passed++;
  endtask

  task automatic test_all_zero;
    int cyc;
    logic [15:0] m; logic [3:0] ix; logic [19:0] b;
    for (int i = 0; i < W; i++) mem[i] = 16'd0;
    ref_model(m, ix, b);
    start_scan();
    total++; if (bus.busy !== 1'b1 || bus.rd_addr !== 4'd0) begin
      $display("FAIL zero_accept busy=%b addr=%0d expected busy=1 addr=0", bus.busy, bus.rd_addr);
    end else passed++;
    wait_done(cyc);
    total++; if (cyc != LAT) $display("FAIL zero_latency got %0d expected %0d", cyc, LAT); else passed++;
    total++; if (bus.max_count !== m || bus.max_index !== ix || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL zero_result cnt=%0d idx=%0d err=%b busy=%b expected %0d %0d 0 0",
               bus.max_count, bus.max_index, bus.err, bus.busy, m, ix);
    end else passed++;
  endtask

  task automatic test_peak;
    int cyc;
    logic [15:0] m; logic [3:0] ix; logic [19:0] b;
    for (int i = 0; i < W; i++) mem[i] = 16'(i);
    mem[7] = 16'd111;
    ref_model(m, ix, b);
    start_scan();
    wait_done(cyc);
    total++; if (cyc != LAT) $display("FAIL peak_latency got %0d expected %0d", cyc, LAT); else passed++;
    total++; if (bus.max_count !== m || bus.max_index !== ix) begin
      $display("FAIL peak_result cnt=%0d idx=%0d expected %0d %0d", bus.max_count, bus.max_index, m, ix);
    end else passed++;
    total++; if (bus.max_bcd !== b) $display("FAIL peak_bcd got %h expected %h", bus.max_bcd, b); else passed++;
  endtask

  task automatic test_ties;
    int cyc;
    logic [15:0] m; logic [3:0] ix; logic [19:0] b;
    for (int i = 0; i < W; i++) mem[i] = 16'($urandom_range(0, 99));
    mem[3] = 16'd100; mem[12] = 16'd100;
    ref_model(m, ix, b);
    start_scan();
    wait_done(cyc);
    total++; if (bus.max_count !== m || bus.max_index !== ix) begin
      $display("FAIL tie_result cnt=%0d idx=%0d expected %0d %0d", bus.max_count, bus.max_index, m, ix);
    end else passed++;
    mem[15] = 16'hFFFF;
    ref_model(m, ix, b);
    start_scan();
    wait_done(cyc);
    total++; if (bus.max_count !== m || bus.max_index !== ix) begin
      $display("FAIL last_word cnt=%0d idx=%0d expected %0d %0d", bus.max_count, bus.max_index, m, ix);
    end else passed++;
    total++; if (bus.max_bcd !== b) $display("FAIL last_bcd got %h expected %h", bus.max_bcd, b); else passed++;
  endtask

  task automatic test_wait;
    int cyc;
    logic [15:0] m; logic [3:0] ix; logic [19:0] b;
    for (int i = 0; i < W; i++) mem[i] = 16'($urandom);
    ref_model(m, ix, b);
    bus.range_done = 1'b0;
    start_scan();
    total++; if (bus.busy !== 1'b1 || bus.rd_addr !== 4'd0 || bus.done !== 1'b0) begin
      $display("FAIL wait_accept busy=%b addr=%0d done=%b expected 1 0 0", bus.busy, bus.rd_addr, bus.done);
    end else passed++;
    for (int i = 0; i < 4; i++) tick();
    total++; if (bus.busy !== 1'b1 || bus.rd_addr !== 4'd0) begin
      $display("FAIL wait_hold busy=%b addr=%0d expected 1 0", bus.busy, bus.rd_addr);
    end else passed++;
    bus.range_done = 1'b1;
    tick();
    wait_done(cyc);
    total++; if (cyc != LAT) $display("FAIL wait_latency got %0d expected %0d", cyc, LAT); else passed++;
    total++; if (bus.max_count !== m || bus.max_index !== ix || bus.max_bcd !== b) begin
      $display("FAIL wait_result cnt=%0d idx=%0d bcd=%h expected %0d %0d %h",
               bus.max_count, bus.max_index, bus.max_bcd, m, ix, b);
    end else passed++;
  endtask

  task automatic test_abort;
    int cyc;
    logic [15:0] m; logic [3:0] ix; logic [19:0] b;
    for (int i = 0; i < W; i++) mem[i] = 16'($urandom);
    ref_model(m, ix, b);
    start_scan();
    for (int i = 0; i < 5; i++) tick();
    bus.range_done = 1'b0;
    tick();
    total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL abort_flags err/busy/done=%b%b%b expected 100", bus.err, bus.busy, bus.done);
    end else passed++;
    bus.range_done = 1'b1;
    start_scan();
    total++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL abort_rescan err=%b busy=%b expected 0 1", bus.err, bus.busy);
    end else passed++;
    wait_done(cyc);
    total++; if (cyc != LAT || bus.max_count !== m || bus.max_index !== ix) begin
      $display("FAIL abort_result lat=%0d cnt=%0d idx=%0d expected %0d %0d %0d",
               cyc, bus.max_count, bus.max_index, LAT, m, ix);
    end else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [15:0] m; logic [3:0] ix; logic [19:0] b;
    for (int i = 0; i < W; i++) mem[i] = 16'hF000 | 16'($urandom_range(0, 4095));
    start_scan();
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.rd_addr !== 4'd0 ||
                 bus.max_count !== 16'd0 || bus.max_index !== 4'd0 || bus.max_bcd !== 20'h0) begin
      $display("FAIL midscan_reset busy=%b done=%b err=%b addr=%0d cnt=%0d idx=%0d bcd=%h expected zeros",
               bus.busy, bus.done, bus.err, bus.rd_addr, bus.max_count, bus.max_index, bus.max_bcd);
    end else passed++;
    for (int i = 0; i < W; i++) mem[i] = 16'($urandom_range(0, 30));
    ref_model(m, ix, b);
    start_scan();
    tick(); tick();
    bus.scan = 1'b1;
    tick(); tick();
    bus.scan = 1'b0;
    wait_done(cyc);
    total++; if (cyc + 4 != LAT) $display("FAIL busy_scan_latency got %0d expected %0d", cyc + 4, LAT); else passed++;
    total++; if (bus.max_count !== m || bus.max_index !== ix || bus.max_bcd !== b) begin
      $display("FAIL busy_scan_result cnt=%0d idx=%0d bcd=%h expected %0d %0d %h",
               bus.max_count, bus.max_index, bus.max_bcd, m, ix, b);
    end else passed++;
  endtask

  task automatic test_random;
    int cyc;
    logic [15:0] m; logic [3:0] ix; logic [19:0] b;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < W; i++)
        mem[i] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      ref_model(m, ix, b);
      start_scan();
      wait_done(cyc);
      total++; if (cyc != LAT || bus.max_count !== m || bus.max_index !== ix || bus.max_bcd !== b) begin
        $display("FAIL random_%0d lat=%0d cnt=%0d idx=%0d bcd=%h expected %0d %0d %0d %h",
                 r, cyc, bus.max_count, bus.max_index, bus.max_bcd, LAT, m, ix, b);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_peak();
    test_ties();
    test_wait();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
